// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Provides data/opcode widths, the arbiter state encoding and the owner encoding.
package alu_arb_pkg;

  localparam int unsigned W  = 16;  // data width, fixed by the ALU
  localparam int unsigned OW = 3;   // opcode width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
//   master: requester side (drives req/opcode/operands/carry for A and B)
//   slave : arbiter side (drives gnt/done pulses, result, flags, busy)
interface alu_rr_arbiter_if;
  import alu_arb_pkg::*;

  logic                 req_a;
  logic [OW-1:0]        opc_a;
  logic signed [W-1:0]  n_a;
  logic signed [W-1:0]  m_a;
  logic                 c_a;

  logic                 req_b;
  logic [OW-1:0]        opc_b;
  logic signed [W-1:0]  n_b;
  logic signed [W-1:0]  m_b;
  logic                 c_b;

  logic                 gnt_a;
  logic                 gnt_b;
  logic                 done_a;
  logic                 done_b;
  logic signed [W-1:0]  f;
  logic                 zer;
  logic                 neg;
  logic                 busy;

  modport master (
    output req_a, opc_a, n_a, m_a, c_a,
    output req_b, opc_b, n_b, m_b, c_b,
    input  gnt_a, gnt_b, done_a, done_b, f, zer, neg, busy
  );

  modport slave (
    input  req_a, opc_a, n_a, m_a, c_a,
    input  req_b, opc_b, n_b, m_b, c_b,
    output gnt_a, gnt_b, done_a, done_b, f, zer, neg, busy
  );

endinterface

// File: rtl/alu_structural_s.sv
// Combinational 16-bit signed ALU.
//   n, m : signed operands      opc : operation select     c : carry/borrow in
//   f    : result               zer : f == 0               neg : f[W-1]
// Opcodes: 0 n+m+c, 1 n-m-c, 2 and, 3 or, 4 xor, 5 ~n, 6 n<<1, 7 n>>>1.
module alu_structural_s
  import alu_arb_pkg::*;
(
  input  logic signed [W-1:0] n,
  input  logic signed [W-1:0] m,
  input  logic [OW-1:0]       opc,
  input  logic                c,
  output logic signed [W-1:0] f,
  output logic                zer,
  output logic                neg
);

  logic [W-1:0] w_c_ext;

  assign w_c_ext = {{(W-1){1'b0}}, c};

  always_comb begin
    f = '0;
    case (opc)
      3'd0:    f = n + m + $signed(w_c_ext);
      3'd1:    f = n - m - $signed(w_c_ext);
      3'd2:    f = n & m;
      3'd3:    f = n | m;
      3'd4:    f = n ^ m;
      3'd5:    f = ~n;
      3'd6:    f = {n[W-2:0], 1'b0};
      3'd7:    f = {n[W-1], n[W-1:1]};
      default: f = '0;
    endcase
  end

  assign zer = (f == '0);
  assign neg = f[W-1];

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one alu_structural_s between requesters A and B.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : slave side of alu_rr_arbiter_if (requests in, grants/results out)
// Flow: IDLE samples requests and latches the winner's operands, EXEC pulses gnt
// and captures the ALU result, RESP pulses done, then back to IDLE.
module alu_rr_arbiter
  import alu_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_rr_arbiter_if.slave bus
);

  state_e               r_state;
  owner_e               r_owner;
  owner_e               r_last;
  logic [OW-1:0]        r_opc;
  logic signed [W-1:0]  r_n;
  logic signed [W-1:0]  r_m;
  logic                 r_c;
  logic                 r_gnt_a;
  logic                 r_gnt_b;
  logic                 r_done_a;
  logic                 r_done_b;
  logic signed [W-1:0]  r_f;
  logic                 r_zer;
  logic                 r_neg;
  logic                 r_busy;

  owner_e               w_win;
  logic signed [W-1:0]  w_f;
  logic                 w_zer;
  logic                 w_neg;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    w_win = OWN_A;
    if (bus.req_a && bus.req_b) begin
      w_win = (r_last == OWN_A) ? OWN_B : OWN_A;
    end else if (bus.req_b) begin
      w_win = OWN_B;
    end
  end

  alu_structural_s u_alu (
    .n   (r_n),
    .m   (r_m),
    .opc (r_opc),
    .c   (r_c),
    .f   (w_f),
    .zer (w_zer),
    .neg (w_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_A;
      r_last   <= OWN_B;  // A wins the first contention
      r_opc    <= '0;
      r_n      <= '0;
      r_m      <= '0;
      r_c      <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      r_f      <= '0;
      r_zer    <= 1'b0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            r_owner <= w_win;
            r_last  <= w_win;
            if (w_win == OWN_A) begin
              r_opc   <= bus.opc_a;
              r_n     <= bus.n_a;
              r_m     <= bus.m_a;
              r_c     <= bus.c_a;
              r_gnt_a <= 1'b1;
            end else begin
              r_opc   <= bus.opc_b;
              r_n     <= bus.n_b;
              r_m     <= bus.m_b;
              r_c     <= bus.c_b;
              r_gnt_b <= 1'b1;
            end
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_f      <= w_f;
          r_zer    <= w_zer;
          r_neg    <= w_neg;
          r_done_a <= (r_owner == OWN_A);
          r_done_b <= (r_owner == OWN_B);
          r_state  <= RESP;
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_a  = r_gnt_a;
  assign bus.gnt_b  = r_gnt_b;
  assign bus.done_a = r_done_a;
  assign bus.done_b = r_done_b;
  assign bus.f      = r_f;
  assign bus.zer    = r_zer;
  assign bus.neg    = r_neg;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rr_arbiter_if u_if ();

  alu_rr_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic [2:0]  opc;
    logic [15:0] n;
    logic [15:0] m;
    logic        c;
    logic [15:0] f;
    logic        zer;
    logic        neg;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] res();
    return {u_if.neg, u_if.zer, $unsigned(u_if.f)};
  endfunction

  // Reference ALU written with integer arithmetic; returns {neg, zer, f}.
  function automatic logic [17:0] model(input logic [2:0] opc, input logic signed [15:0] n,
                                        input logic signed [15:0] m, input logic c);
    int r;
    logic [15:0] fv;
    case (opc)
      3'd0:    r = int'(n) + int'(m) + int'(c);
      3'd1:    r = int'(n) - int'(m) - int'(c);
      3'd2:    r = int'(n) & int'(m);
      3'd3:    r = int'(n) | int'(m);
      3'd4:    r = int'(n) ^ int'(m);
      3'd5:    r = ~int'(n);
      3'd6:    r = int'(n) * 2;
      default: r = int'(n) >>> 1;
    endcase
    fv = r[15:0];
    return {fv[15], fv == 16'h0, fv};
  endfunction

  task automatic clear_reqs;
    u_if.req_a = 1'b0; u_if.opc_a = '0; u_if.n_a = '0; u_if.m_a = '0; u_if.c_a = 1'b0;
    u_if.req_b = 1'b0; u_if.opc_b = '0; u_if.n_b = '0; u_if.m_b = '0; u_if.c_b = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_a(input logic [2:0] opc, input logic [15:0] n, input logic [15:0] m,
                       input logic c);
    u_if.opc_a = opc; u_if.n_a = n; u_if.m_a = m; u_if.c_a = c; u_if.req_a = 1'b1;
  endtask

  task automatic set_b(input logic [2:0] opc, input logic [15:0] n, input logic [15:0] m,
                       input logic c);
    u_if.opc_b = opc; u_if.n_b = n; u_if.m_b = m; u_if.c_b = c; u_if.req_b = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int order [$];
    int done_cyc [$];
    int viol;
    int ga, gb, da, db;
    logic [17:0] exp_a, exp_b;
    logic rearm_a, rearm_b;

    vecs[0]  = '{opc: 3'd0, n: 16'h0008, m: 16'h0003, c: 1'b0, f: 16'h000B, zer: 1'b0, neg: 1'b0};
    vecs[1]  = '{opc: 3'd1, n: 16'hFFFB, m: 16'h0007, c: 1'b0, f: 16'hFFF4, zer: 1'b0, neg: 1'b1};
    vecs[2]  = '{opc: 3'd0, n: 16'h7FFF, m: 16'h0001, c: 1'b0, f: 16'h8000, zer: 1'b0, neg: 1'b1};
    vecs[3]  = '{opc: 3'd0, n: 16'hFFFF, m: 16'h0001, c: 1'b0, f: 16'h0000, zer: 1'b1, neg: 1'b0};
    vecs[4]  = '{opc: 3'd0, n: 16'h0005, m: 16'h0006, c: 1'b1, f: 16'h000C, zer: 1'b0, neg: 1'b0};
    vecs[5]  = '{opc: 3'd1, n: 16'h000A, m: 16'h0003, c: 1'b1, f: 16'h0006, zer: 1'b0, neg: 1'b0};
    vecs[6]  = '{opc: 3'd2, n: 16'h00F0, m: 16'h0FF0, c: 1'b0, f: 16'h00F0, zer: 1'b0, neg: 1'b0};
    vecs[7]  = '{opc: 3'd3, n: 16'h00F0, m: 16'h0F00, c: 1'b0, f: 16'h0FF0, zer: 1'b0, neg: 1'b0};
    vecs[8]  = '{opc: 3'd4, n: 16'hFFFF, m: 16'hFFFF, c: 1'b0, f: 16'h0000, zer: 1'b1, neg: 1'b0};
    vecs[9]  = '{opc: 3'd5, n: 16'h0000, m: 16'h1234, c: 1'b0, f: 16'hFFFF, zer: 1'b0, neg: 1'b1};
    vecs[10] = '{opc: 3'd6, n: 16'h4001, m: 16'h0000, c: 1'b0, f: 16'h8002, zer: 1'b0, neg: 1'b1};
    vecs[11] = '{opc: 3'd7, n: 16'h8004, m: 16'h0000, c: 1'b0, f: 16'hC002, zer: 1'b0, neg: 1'b1};

    // Reset state
    clear_reqs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_pulses", 18'({u_if.gnt_a, u_if.gnt_b, u_if.done_a, u_if.done_b}), 18'h0);
    check("reset_result", res(), 18'h0);
    check("reset_busy", 18'(u_if.busy), 18'h0);
    apply_reset();

    // Single-requester vectors through A
    foreach (vecs[i]) begin
      set_a(vecs[i].opc, vecs[i].n, vecs[i].m, vecs[i].c);
      tick();
      check($sformatf("vec%0d_gnt", i), 18'({u_if.gnt_a, u_if.gnt_b, u_if.done_a, u_if.busy}),
            18'b1001);
      u_if.req_a = 1'b0;
      tick();
      check($sformatf("vec%0d_done", i), 18'({u_if.gnt_a, u_if.gnt_b, u_if.done_a, u_if.done_b}),
            18'b0010);
      check($sformatf("vec%0d_res", i), res(), {vecs[i].neg, vecs[i].zer, vecs[i].f});
      tick();
      check($sformatf("vec%0d_hold", i), {res()}, {vecs[i].neg, vecs[i].zer, vecs[i].f});
      check($sformatf("vec%0d_idle", i), 18'({u_if.busy, u_if.done_a}), 18'h0);
    end

    // Simultaneous first request after reset: A first, B three cycles later
    apply_reset();
    set_a(3'd0, 16'd8, 16'd3, 1'b0);
    set_b(3'd1, 16'hFFFB, 16'd7, 1'b0);
    tick();
    check("sim_gnt_a", 18'({u_if.gnt_a, u_if.gnt_b}), 18'b10);
    u_if.req_a = 1'b0;
    tick();
    check("sim_done_a", 18'({u_if.done_a, u_if.done_b}), 18'b10);
    check("sim_res_a", res(), model(3'd0, 16'd8, 16'd3, 1'b0));
    tick();
    check("sim_idle_gap", 18'({u_if.gnt_a, u_if.gnt_b, u_if.busy}), 18'h0);
    tick();
    check("sim_gnt_b", 18'({u_if.gnt_a, u_if.gnt_b}), 18'b01);
    u_if.req_b = 1'b0;
    tick();
    check("sim_done_b", 18'({u_if.done_a, u_if.done_b}), 18'b01);
    check("sim_res_b", res(), 18'h2FFF4);
    tick();

    // Continuous contention: six operations alternate A,B,...
    apply_reset();
    set_a(3'd0, 16'd8, 16'd3, 1'b0);
    set_b(3'd1, 16'hFFFB, 16'd7, 1'b0);
    viol = 0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      tick();
      if (u_if.gnt_a && u_if.gnt_b) viol++;
      if (u_if.done_a && u_if.done_b) viol++;
      if ((u_if.gnt_a || u_if.gnt_b) && (u_if.done_a || u_if.done_b)) viol++;
      if (u_if.gnt_a) order.push_back(0);
      if (u_if.gnt_b) order.push_back(1);
      if (u_if.done_a) begin
        done_cyc.push_back(cyc);
        check("cont_res_a", res(), 18'h0000B);
      end
      if (u_if.done_b) begin
        done_cyc.push_back(cyc);
        check("cont_res_b", res(), 18'h2FFF4);
      end
    end
    clear_reqs();
    check("cont_grants", 18'(order.size()), 18'd6);
    check("cont_dones", 18'(done_cyc.size()), 18'd6);
    check("cont_excl", 18'(viol), 18'd0);
    for (int i = 0; i < order.size() && i < 6; i++) begin
      check($sformatf("cont_order%0d", i), 18'(order[i]), 18'(i % 2));
    end
    for (int i = 1; i < done_cyc.size(); i++) begin
      check($sformatf("cont_spacing%0d", i), 18'(done_cyc[i] - done_cyc[i-1]), 18'd3);
    end
    repeat (3) tick();

    // Operand change in the grant cycle does not affect the result
    apply_reset();
    set_a(3'd0, 16'd8, 16'd3, 1'b0);
    tick();
    check("chg_gnt", 18'(u_if.gnt_a), 18'd1);
    u_if.n_a = 16'd100;
    u_if.req_a = 1'b0;
    tick();
    check("chg_res", res(), 18'h0000B);
    tick();

    // Reset during B's EXEC cycle
    apply_reset();
    set_a(3'd0, 16'd8, 16'd3, 1'b0);
    tick();
    u_if.req_a = 1'b0;
    tick();
    tick();
    set_b(3'd1, 16'hFFFB, 16'd7, 1'b0);
    tick();
    check("rst_gnt_b", 18'(u_if.gnt_b), 18'd1);
    rst_n = 1'b0;
    u_if.req_b = 1'b0;
    #1;
    check("rst_res", res(), 18'h0);
    check("rst_outs", 18'({u_if.gnt_a, u_if.gnt_b, u_if.done_a, u_if.done_b, u_if.busy}), 18'h0);
    tick();
    check("rst_no_done", 18'({u_if.done_a, u_if.done_b}), 18'h0);
    rst_n = 1'b1;
    set_a(3'd2, 16'h00FF, 16'h0F0F, 1'b0);
    set_b(3'd3, 16'h00FF, 16'h0F0F, 1'b0);
    tick();
    check("rst_a_first", 18'({u_if.gnt_a, u_if.gnt_b}), 18'b10);
    clear_reqs();
    repeat (3) tick();

    // Reset during A's EXEC restores priority to A
    set_a(3'd0, 16'd1, 16'd1, 1'b0);
    tick();
    check("rst2_gnt_a", 18'(u_if.gnt_a), 18'd1);
    rst_n = 1'b0;
    clear_reqs();
    tick();
    rst_n = 1'b1;
    set_a(3'd0, 16'd1, 16'd1, 1'b0);
    set_b(3'd0, 16'd2, 16'd2, 1'b0);
    tick();
    check("rst2_a_first", 18'({u_if.gnt_a, u_if.gnt_b}), 18'b10);
    clear_reqs();
    repeat (3) tick();

    // Randomised operations, 7 per requester, covering opcodes 0..7
    apply_reset();
    ga = 0; gb = 0; da = 0; db = 0; viol = 0;
    exp_a = '0; exp_b = '0;
    rearm_a = 1'b0; rearm_b = 1'b0;
    set_a(3'(ga), 16'($urandom), 16'($urandom), 1'($urandom));
    set_b(3'(gb + 1), 16'($urandom), 16'($urandom), 1'($urandom));
    for (int cyc = 0; cyc < 300 && (da < 7 || db < 7); cyc++) begin
      tick();
      if (u_if.gnt_a && u_if.gnt_b) viol++;
      if (u_if.done_a && u_if.done_b) viol++;
      if ((u_if.gnt_a || u_if.gnt_b) && (u_if.done_a || u_if.done_b)) viol++;
      if (u_if.done_a) begin
        da++;
        check("rand_a", res(), exp_a);
      end
      if (u_if.done_b) begin
        db++;
        check("rand_b", res(), exp_b);
      end
      if (rearm_a && ga < 7) set_a(3'(ga), 16'($urandom), 16'($urandom), 1'($urandom));
      if (rearm_b && gb < 7) set_b(3'(gb + 1), 16'($urandom), 16'($urandom), 1'($urandom));
      rearm_a = 1'b0;
      rearm_b = 1'b0;
      if (u_if.gnt_a) begin
        exp_a = model(u_if.opc_a, u_if.n_a, u_if.m_a, u_if.c_a);
        u_if.req_a = 1'b0;
        ga++;
        rearm_a = 1'b1;
      end
      if (u_if.gnt_b) begin
        exp_b = model(u_if.opc_b, u_if.n_b, u_if.m_b, u_if.c_b);
        u_if.req_b = 1'b0;
        gb++;
        rearm_b = 1'b1;
      end
    end
    clear_reqs();
    check("rand_done_a", 18'(da), 18'd7);
    check("rand_done_b", 18'(db), 18'd7);
    check("rand_gnt_eq_done_a", 18'(ga), 18'(da));
    check("rand_gnt_eq_done_b", 18'(gb), 18'(db));
    check("rand_excl", 18'(viol), 18'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 16-bit signed ALU (alu_structural_s) between two requesters, A and B.
- Arbitrates round-robin, registers the winner's operands, runs one ALU evaluation, registers the result and flags, and returns them with a done pulse to the winner.
- Sits between requester FSMs and the ALU; the ALU is instantiated inside.

Parameters:
- W, 16, data width; must stay 16 to match the ALU.
- OW, 3, opcode width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A request; held until gnt_a.
- opc_a  in  OW  A opcode.
- n_a  in  W  A operand n, signed.
- m_a  in  W  A operand m, signed.
- c_a  in  1  A carry-in.
- req_b, opc_b, n_b, m_b, c_b  in  1/OW/W/W/1  same as A, for requester B.
- gnt_a  out  1  one-cycle pulse: A's operands captured.
- gnt_b  out  1  same, for B.
- done_a  out  1  one-cycle pulse: result valid for A.
- done_b  out  1  same, for B.
- f  out  W  registered signed ALU result.
- zer  out  1  registered zero flag.
- neg  out  1  registered negative flag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE; opcode and operand registers = 0; last=B, so A wins first.
  - gnt_a/b=0, done_a/b=0, f=0, zer=0, neg=0, busy=0.
- States IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - At an edge with req_a|req_b high: pick the winner, latch its opc/n/m/c, record owner, set last=winner, go to EXEC.
  - No request: stay in IDLE.
- Winner pick:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last wins (strict alternation under contention).
- EXEC (one cycle):
  - gnt_<owner>=1; the ALU sees the latched operands.
  - At the edge, f/zer/neg <= ALU outputs; go to RESP.
- RESP (one cycle):
  - done_<owner>=1; go to IDLE.
- Result hold: f/zer/neg hold their value until the next EXEC->RESP edge; they do not revert after done.
- Latency: req sampled at edge k gives gnt high in cycle k+1 and done high in cycle k+2. Throughput is one operation per 3 cycles.
- Requester rule:
  - Keep req and operands stable until gnt is seen; drop req in the gnt cycle.
  - A req still high when the arbiter returns to IDLE (RESP->IDLE edge sampled, so first IDLE edge) is a new request.
  - Requests are never sampled in EXEC or RESP.
- Pending requester: a losing request stays pending and wins at the next IDLE sample if still asserted. There is no starvation: under continuous contention the maximum wait is one operation.
- Operand changes after capture do not affect the in-flight operation.
- Arithmetic: no width changes; f, zer and neg come directly from the ALU; the arbiter does not recompute flags.
- gnt_a and gnt_b are never both high; done_a and done_b are never both high; gnt and done are never high in the same cycle.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no done is issued, and all outputs go to reset values immediately.

Decomposition:
- Shared package alu_arb_pkg:
  - W=16, OW=3;
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - owner encoding OWN_A=1'b0, OWN_B=1'b1.
- Sub-module: one instance of the existing alu_structural_s (n, m, opc, c -> f, zer, neg).
- Arbitration logic stays inline; it is too small to split.

Test Plan:
- Reset then A only: req_a=1, n_a=8, m_a=3, opc_a=0, c_a=0 -> gnt_a at k+1, done_a at k+2, f/zer/neg equal to a standalone alu_structural_s for the same inputs; gnt_b/done_b stay 0.
- Simultaneous first request: req_a=req_b=1 after reset -> A served first. B, held, gets gnt_b exactly 3 cycles after gnt_a. Check f for B's inputs n_b=-5, m_b=7, opc_b=1.
- Continuous contention: both req re-asserted immediately for 6 operations -> grant order A,B,A,B,A,B; one done per 3 cycles.
- Operand change after gnt: change n_a from 8 to 100 in the gnt_a cycle -> f corresponds to n=8.
- Reset mid-EXEC: drop rst_n during gnt_b -> no done_b; f=0, zer=0, neg=0, busy=0 at once. After release, A wins the first contention.
- Randomised: 7 operations per requester with $random operands and all opcodes 0..7 -> every f/zer/neg matches the standalone ALU model, and done counts equal grant counts.
